// File: rtl/alu_op_sequencer_pkg.sv
// Shared encodings for the ALU op sequencer: instruction fields, ALU control
// codes, operand-b select and the controller state type.
package alu_op_sequencer_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [3:0] GIN_AND  = 4'b0000;
  localparam logic [3:0] GIN_OR   = 4'b0001;
  localparam logic [3:0] GIN_ADD  = 4'b0010;
  localparam logic [3:0] GIN_SUB  = 4'b0110;
  localparam logic [3:0] GIN_SLT  = 4'b0111;
  localparam logic [3:0] GIN_BNE  = 4'b1000;
  localparam logic [3:0] GIN_BGEZ = 4'b1001;
  localparam logic [3:0] GIN_BGTZ = 4'b1011;
  localparam logic [3:0] GIN_NOR  = 4'b1100;
  localparam logic [3:0] GIN_BLEZ = 4'b1101;
  localparam logic [3:0] GIN_BLTZ = 4'b1110;
  localparam logic [3:0] GIN_PASS = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_BRCALC = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    B_SEL_RT   = 2'd0,
    B_SEL_IMM  = 2'd1,
    B_SEL_ZERO = 2'd2
  } b_sel_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction, ALU and result channels of the ALU op sequencer.
interface alu_op_sequencer_if;

  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [4:0]  in_rt;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [15:0] in_imm;
  logic [31:0] in_pc;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_gin;
  logic [31:0] alu_sum;
  logic        alu_zout;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_is_branch;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_opcode, in_funct, in_rt, in_rs_val, in_rt_val, in_imm, in_pc,
    output in_ready,
    output alu_a, alu_b, alu_gin,
    input  alu_sum, alu_zout,
    output out_valid, out_result, out_is_branch, out_taken, out_target, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_opcode, in_funct, in_rt, in_rs_val, in_rt_val, in_imm, in_pc,
    input  in_ready,
    input  alu_a, alu_b, alu_gin,
    output alu_sum, alu_zout,
    input  out_valid, out_result, out_is_branch, out_taken, out_target, out_illegal,
    output out_ready
  );

endinterface

// File: rtl/alu_op_sequencer_decode.sv
// Combinational decode of opcode/funct/rt into ALU control code, operand-b
// select, immediate extension mode, branch flag and illegal flag.
module alu_op_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output logic [3:0] gin,
  output b_sel_e     b_sel,
  output logic       imm_sext,
  output logic       is_branch,
  output logic       illegal
);

  // Map the instruction encoding onto ALU control and operand selection.
  always_comb begin
    gin       = GIN_PASS;
    b_sel     = B_SEL_RT;
    imm_sext  = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  gin = GIN_ADD;
          FN_SUB:  gin = GIN_SUB;
          FN_AND:  gin = GIN_AND;
          FN_OR:   gin = GIN_OR;
          FN_NOR:  gin = GIN_NOR;
          FN_SLT:  gin = GIN_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        gin      = GIN_ADD;
        b_sel    = B_SEL_IMM;
        imm_sext = 1'b1;
      end
      OP_ANDI: begin
        gin   = GIN_AND;
        b_sel = B_SEL_IMM;
      end
      OP_ORI: begin
        gin   = GIN_OR;
        b_sel = B_SEL_IMM;
      end
      OP_BEQ: begin
        gin       = GIN_SUB;
        is_branch = 1'b1;
      end
      OP_BNE: begin
        gin       = GIN_BNE;
        is_branch = 1'b1;
      end
      OP_BLEZ: begin
        gin       = GIN_BLEZ;
        b_sel     = B_SEL_ZERO;
        is_branch = 1'b1;
      end
      OP_BGTZ: begin
        gin       = GIN_BGTZ;
        b_sel     = B_SEL_ZERO;
        is_branch = 1'b1;
      end
      OP_REGIMM: begin
        b_sel = B_SEL_ZERO;
        case (rt)
          RT_BLTZ: begin
            gin       = GIN_BLTZ;
            is_branch = 1'b1;
          end
          RT_BGEZ: begin
            gin       = GIN_BGEZ;
            is_branch = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    // Illegal encodings never issue, so the control line stays at pass-through.
    if (illegal) begin
      gin = GIN_PASS;
    end else begin
      gin = gin;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue controller: captures one decoded instruction, drives the
// shared ALU for the operation and the branch-target add, and holds the result.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [5:0]  funct_q, funct_d;
  logic [4:0]  rt_q, rt_d;
  logic [31:0] rs_val_q, rs_val_d;
  logic [31:0] rt_val_q, rt_val_d;
  logic [15:0] imm_q, imm_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        is_branch_q, is_branch_d;
  logic        illegal_q, illegal_d;
  logic [31:0] res_q, res_d;
  logic        taken_q, taken_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_gin_q, alu_gin_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic        out_is_branch_q, out_is_branch_d;
  logic        out_taken_q, out_taken_d;
  logic [31:0] out_target_q, out_target_d;
  logic        out_illegal_q, out_illegal_d;

  logic [3:0]  dec_gin_s;
  b_sel_e      dec_b_sel_s;
  logic        dec_imm_sext_s;
  logic        dec_is_branch_s;
  logic        dec_illegal_s;

  alu_op_decode u_decode (
    .opcode    (opcode_q),
    .funct     (funct_q),
    .rt        (rt_q),
    .gin       (dec_gin_s),
    .b_sel     (dec_b_sel_s),
    .imm_sext  (dec_imm_sext_s),
    .is_branch (dec_is_branch_s),
    .illegal   (dec_illegal_s)
  );

  // Next-state, datapath capture and output-register load.
  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    funct_d         = funct_q;
    rt_d            = rt_q;
    rs_val_d        = rs_val_q;
    rt_val_d        = rt_val_q;
    imm_d           = imm_q;
    pc_d            = pc_q;
    pc4_d           = pc4_q;
    is_branch_d     = is_branch_q;
    illegal_d       = illegal_q;
    res_d           = res_q;
    taken_d         = taken_q;
    tgt_d           = tgt_q;
    out_valid_d     = out_valid_q;
    out_result_d    = out_result_q;
    out_is_branch_d = out_is_branch_q;
    out_taken_d     = out_taken_q;
    out_target_d    = out_target_q;
    out_illegal_d   = out_illegal_q;
    alu_a_d         = 32'h0000_0000;
    alu_b_d         = 32'h0000_0000;
    alu_gin_d       = GIN_PASS;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          opcode_d = bus.in_opcode;
          funct_d  = bus.in_funct;
          rt_d     = bus.in_rt;
          rs_val_d = bus.in_rs_val;
          rt_val_d = bus.in_rt_val;
          imm_d    = bus.in_imm;
          pc_d     = bus.in_pc;
          state_d  = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        pc4_d       = pc_q + PC_INC;
        is_branch_d = dec_is_branch_s;
        illegal_d   = dec_illegal_s;
        if (dec_illegal_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = bus.alu_sum;
        taken_d = bus.alu_zout;
        if (is_branch_q) begin
          state_d = ST_BRCALC;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_BRCALC: begin
        tgt_d   = taken_q ? bus.alu_sum : pc4_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // First DONE cycle loads the result registers; they then hold until accepted.
        if (!out_valid_q) begin
          out_valid_d     = 1'b1;
          out_result_d    = (is_branch_q || illegal_q) ? 32'h0000_0000 : res_q;
          out_is_branch_d = is_branch_q;
          out_taken_d     = is_branch_q & taken_q;
          out_target_d    = is_branch_q ? tgt_q : 32'h0000_0000;
          out_illegal_d   = illegal_q;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // ALU lines are registered, so they are computed from the state being entered.
    case (state_d)
      ST_EXEC: begin
        alu_a_d   = rs_val_q;
        alu_gin_d = dec_gin_s;
        case (dec_b_sel_s)
          B_SEL_RT:   alu_b_d = rt_val_q;
          B_SEL_IMM:  alu_b_d = dec_imm_sext_s ? sext16(imm_q) : {16'h0000, imm_q};
          B_SEL_ZERO: alu_b_d = 32'h0000_0000;
          default:    alu_b_d = 32'h0000_0000;
        endcase
      end
      ST_BRCALC: begin
        alu_a_d   = pc4_q;
        alu_b_d   = sext16(imm_q) << 2;
        alu_gin_d = GIN_ADD;
      end
      default: begin
        alu_a_d   = 32'h0000_0000;
        alu_b_d   = 32'h0000_0000;
        alu_gin_d = GIN_PASS;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      opcode_q        <= 6'b000000;
      funct_q         <= 6'b000000;
      rt_q            <= 5'b00000;
      rs_val_q        <= 32'h0000_0000;
      rt_val_q        <= 32'h0000_0000;
      imm_q           <= 16'h0000;
      pc_q            <= 32'h0000_0000;
      pc4_q           <= 32'h0000_0000;
      is_branch_q     <= 1'b0;
      illegal_q       <= 1'b0;
      res_q           <= 32'h0000_0000;
      taken_q         <= 1'b0;
      tgt_q           <= 32'h0000_0000;
      alu_a_q         <= 32'h0000_0000;
      alu_b_q         <= 32'h0000_0000;
      alu_gin_q       <= 4'b0000;
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
      out_result_q    <= 32'h0000_0000;
      out_is_branch_q <= 1'b0;
      out_taken_q     <= 1'b0;
      out_target_q    <= 32'h0000_0000;
      out_illegal_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      opcode_q        <= opcode_d;
      funct_q         <= funct_d;
      rt_q            <= rt_d;
      rs_val_q        <= rs_val_d;
      rt_val_q        <= rt_val_d;
      imm_q           <= imm_d;
      pc_q            <= pc_d;
      pc4_q           <= pc4_d;
      is_branch_q     <= is_branch_d;
      illegal_q       <= illegal_d;
      res_q           <= res_d;
      taken_q         <= taken_d;
      tgt_q           <= tgt_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      alu_gin_q       <= alu_gin_d;
      in_ready_q      <= in_ready_d;
      out_valid_q     <= out_valid_d;
      out_result_q    <= out_result_d;
      out_is_branch_q <= out_is_branch_d;
      out_taken_q     <= out_taken_d;
      out_target_q    <= out_target_d;
      out_illegal_q   <= out_illegal_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_gin       = alu_gin_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_result    = out_result_q;
  assign bus.out_is_branch = out_is_branch_q;
  assign bus.out_taken     = out_taken_q;
  assign bus.out_target    = out_target_q;
  assign bus.out_illegal   = out_illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, directed plan cases,
// randomized instructions against an instruction-level reference model, reset mid-flight.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.PC_INC(32'd4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural ALU: each branch code yields zero exactly when its condition holds.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] g);
    case (g)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1000: return (a == b) ? 32'd1 : 32'd0;
      4'b1101: return ($signed(a) <= 32'sd0) ? 32'd0 : 32'd1;
      4'b1011: return ($signed(a) > 32'sd0) ? 32'd0 : 32'd1;
      4'b1110: return a[31] ? 32'd0 : 32'd1;
      4'b1001: return a[31] ? 32'd1 : 32'd0;
      default: return a;
    endcase
  endfunction

  assign bus.alu_sum  = alu_model(bus.alu_a, bus.alu_b, bus.alu_gin);
  assign bus.alu_zout = (bus.alu_sum == 32'd0);

  typedef struct packed {
    logic        illegal;
    logic        br;
    logic        taken;
    logic [31:0] result;
    logic [31:0] target;
    logic [3:0]  gin;
    logic [2:0]  lat;
  } exp_t;

  // Instruction-level reference: what the instruction means, not how it is sequenced.
  function automatic exp_t ref_model(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] rt, input logic [31:0] rs,
                                     input logic [31:0] rtv, input logic [15:0] imm,
                                     input logic [31:0] pc);
    exp_t e;
    logic [31:0] sx, zx, pc4;
    logic cond;
    e = '0;
    e.gin = 4'hF;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0000, imm};
    pc4 = pc + 32'd4;
    cond = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h20: begin e.result = rs + rtv; e.gin = 4'h2; end
        6'h22: begin e.result = rs - rtv; e.gin = 4'h6; end
        6'h24: begin e.result = rs & rtv; e.gin = 4'h0; end
        6'h25: begin e.result = rs | rtv; e.gin = 4'h1; end
        6'h27: begin e.result = ~(rs | rtv); e.gin = 4'hC; end
        6'h2a: begin e.result = ($signed(rs) < $signed(rtv)) ? 32'd1 : 32'd0; e.gin = 4'h7; end
        default: e.illegal = 1'b1;
      endcase
      6'h08: begin e.result = rs + sx; e.gin = 4'h2; end
      6'h0c: begin e.result = rs & zx; e.gin = 4'h0; end
      6'h0d: begin e.result = rs | zx; e.gin = 4'h1; end
      6'h04: begin e.br = 1'b1; cond = (rs == rtv); e.gin = 4'h6; end
      6'h05: begin e.br = 1'b1; cond = (rs != rtv); e.gin = 4'h8; end
      6'h06: begin e.br = 1'b1; cond = ($signed(rs) <= 32'sd0); e.gin = 4'hD; end
      6'h07: begin e.br = 1'b1; cond = ($signed(rs) > 32'sd0); e.gin = 4'hB; end
      6'h01: begin
        if (rt == 5'd0) begin e.br = 1'b1; cond = ($signed(rs) < 32'sd0); e.gin = 4'hE; end
        else if (rt == 5'd1) begin e.br = 1'b1; cond = ($signed(rs) >= 32'sd0); e.gin = 4'h9; end
        else e.illegal = 1'b1;
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.br) begin
      e.taken  = cond;
      e.target = cond ? pc4 + (sx << 2) : pc4;
    end
    e.lat = e.illegal ? 3'd2 : (e.br ? 3'd4 : 3'd3);
    return e;
  endfunction

  // Issue one instruction, check its latency/ALU control/hold, return what came out.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                           input logic [31:0] rs, input logic [31:0] rtv,
                           input logic [15:0] imm, input logic [31:0] pc,
                           input bit noise, input int hold,
                           output logic [31:0] o_res, output logic [31:0] o_tgt,
                           output logic o_br, output logic o_tk, output logic o_ill);
    exp_t e;
    e = ref_model(op, fn, rt, rs, rtv, imm, pc);
    @(negedge clk);
    for (int i = 0; i < 10 && bus.in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_opcode = op; bus.in_funct = fn; bus.in_rt = rt;
    bus.in_rs_val = rs; bus.in_rt_val = rtv; bus.in_imm = imm; bus.in_pc = pc;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (noise) begin
      bus.in_opcode = 6'($urandom); bus.in_funct = 6'($urandom); bus.in_rt = 5'($urandom);
      bus.in_rs_val = $urandom; bus.in_rt_val = $urandom;
      bus.in_imm = 16'($urandom); bus.in_pc = $urandom;
    end else begin
      bus.in_valid = 1'b0;
    end
    for (int k = 1; k <= int'(e.lat); k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        checks++;
        if (bus.alu_gin !== e.gin) begin
          errors++;
          $display("FAIL exec_gin: alu_gin=%b required %b (op=%b fn=%b)", bus.alu_gin, e.gin, op, fn);
        end
      end
      if (k == 2 && e.br) begin
        checks++;
        if (bus.alu_gin !== 4'b0010 || bus.alu_a !== pc + 32'd4) begin
          errors++;
          $display("FAIL brcalc_drive: gin=%b a=%h required 0010 %h", bus.alu_gin, bus.alu_a, pc + 32'd4);
        end
      end
      if (k < int'(e.lat)) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL early_valid: cycle %0d out_valid=%b in_ready=%b required 0 0", k, bus.out_valid, bus.in_ready);
        end
      end
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: out_valid=%b after %0d cycles required 1", bus.out_valid, e.lat);
    end
    checks++;
    if (bus.alu_gin !== 4'b1111 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
      errors++;
      $display("FAIL done_alu_idle: gin=%b a=%h b=%h required 1111 0 0", bus.alu_gin, bus.alu_a, bus.alu_b);
    end
    o_res = bus.out_result; o_tgt = bus.out_target;
    o_br = bus.out_is_branch; o_tk = bus.out_taken; o_ill = bus.out_illegal;
    bus.in_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_result !== o_res ||
          bus.out_target !== o_tgt || bus.out_is_branch !== o_br || bus.out_taken !== o_tk ||
          bus.out_illegal !== o_ill) begin
        errors++;
        $display("FAIL hold: cycle %0d valid=%b ready=%b res=%h tgt=%h required 1 0 %h %h",
                 h, bus.out_valid, bus.in_ready, bus.out_result, bus.out_target, o_res, o_tgt);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.alu_gin !== 4'b0000 ||
        bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.out_result !== 32'd0 ||
        bus.out_target !== 32'd0 || bus.out_is_branch !== 1'b0 || bus.out_taken !== 1'b0 ||
        bus.out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b gin=%b a=%h res=%h required 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.alu_gin, bus.alu_a, bus.out_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.alu_gin !== 4'b1111 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: gin=%b ready=%b required 1111 1", bus.alu_gin, bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] r, t;
    logic b, k, il;
    run_instr(6'h00, 6'h20, 5'd7, 32'd5, 32'd7, 16'h0000, 32'h0, 1'b0, 0, r, t, b, k, il);
    checks++;
    if (r !== 32'd12 || b !== 1'b0 || il !== 1'b0) begin
      errors++; $display("FAIL add: res=%h br=%b required 0000000c 0", r, b);
    end
    run_instr(6'h00, 6'h2a, 5'd1, 32'hFFFFFFFF, 32'd1, 16'h0000, 32'h0, 1'b0, 0, r, t, b, k, il);
    checks++;
    if (r !== 32'd1) begin errors++; $display("FAIL slt: res=%h required 00000001", r); end
    run_instr(6'h0c, 6'h00, 5'd0, 32'hFFFF1234, 32'd0, 16'h8F0F, 32'h0, 1'b0, 0, r, t, b, k, il);
    checks++;
    if (r !== 32'h00000204) begin errors++; $display("FAIL andi_zext: res=%h required 00000204", r); end
    run_instr(6'h04, 6'h00, 5'd2, 32'd9, 32'd9, 16'hFFFE, 32'h100, 1'b0, 0, r, t, b, k, il);
    checks++;
    if (k !== 1'b1 || t !== 32'h000000FC || b !== 1'b1 || r !== 32'd0) begin
      errors++; $display("FAIL beq_taken: taken=%b tgt=%h res=%h required 1 000000fc 0", k, t, r);
    end
    run_instr(6'h04, 6'h00, 5'd2, 32'd9, 32'd8, 16'hFFFE, 32'h100, 1'b0, 0, r, t, b, k, il);
    checks++;
    if (k !== 1'b0 || t !== 32'h00000104) begin
      errors++; $display("FAIL beq_not_taken: taken=%b tgt=%h required 0 00000104", k, t);
    end
    run_instr(6'h01, 6'h00, 5'd0, 32'h80000000, 32'd0, 16'h0001, 32'hFFFFFFFC, 1'b0, 0, r, t, b, k, il);
    checks++;
    if (k !== 1'b1 || t !== 32'h00000004) begin
      errors++; $display("FAIL bltz_wrap: taken=%b tgt=%h required 1 00000004", k, t);
    end
  endtask

  task automatic test_illegal_hold();
    logic [31:0] r, t;
    logic b, k, il;
    run_instr(6'h3f, 6'h20, 5'd0, 32'd1, 32'd2, 16'h1234, 32'h40, 1'b1, 5, r, t, b, k, il);
    checks++;
    if (il !== 1'b1 || r !== 32'd0 || t !== 32'd0 || b !== 1'b0 || k !== 1'b0) begin
      errors++; $display("FAIL illegal: ill=%b res=%h tgt=%h br=%b required 1 0 0 0", il, r, t, b);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[11] = '{6'h00, 6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h0c, 6'h0d, 6'h3f};
    logic [5:0] fns[7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h21};
    logic [31:0] sp[4]  = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h1};
    logic [5:0] op, fn;
    logic [4:0] rt;
    logic [31:0] rs, rtv, pc, r, t;
    logic [15:0] imm;
    logic b, k, il;
    exp_t e;
    for (int n = 0; n < 150; n++) begin
      op  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
      fn  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      rt  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      rtv = ($urandom_range(0, 2) == 0) ? rs : $urandom;
      imm = 16'($urandom);
      pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | {28'h0, 4'($urandom)}) : {$urandom} & 32'hFFFFFFFC;
      e = ref_model(op, fn, rt, rs, rtv, imm, pc);
      run_instr(op, fn, rt, rs, rtv, imm, pc, 1'($urandom), $urandom_range(0, 2), r, t, b, k, il);
      checks++;
      if (r !== e.result || t !== e.target || b !== e.br || k !== e.taken || il !== e.illegal) begin
        errors++;
        $display("FAIL random_%0d: op=%b fn=%b res=%h tgt=%h br=%b tk=%b ill=%b required %h %h %b %b %b",
                 n, op, fn, r, t, b, k, il, e.result, e.target, e.br, e.taken, e.illegal);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, t;
    logic b, k, il;
    @(negedge clk);
    bus.in_opcode = 6'h04; bus.in_funct = 6'h00; bus.in_rt = 5'd1;
    bus.in_rs_val = 32'd3; bus.in_rt_val = 32'd3; bus.in_imm = 16'h0010; bus.in_pc = 32'h200;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.alu_gin !== 4'b0010) begin
      errors++; $display("FAIL mid_brcalc: gin=%b required 0010", bus.alu_gin);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.alu_gin !== 4'b0000 ||
        bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b valid=%b gin=%b a=%h b=%h required 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.alu_gin, bus.alu_a, bus.alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL mid_reset_emit: cycle %0d out_valid=%b required 0", i, bus.out_valid);
      end
    end
    run_instr(6'h00, 6'h20, 5'd7, 32'd5, 32'd7, 16'h0000, 32'h0, 1'b0, 0, r, t, b, k, il);
    checks++;
    if (r !== 32'd12 || b !== 1'b0) begin
      errors++; $display("FAIL add_after_reset: res=%h required 0000000c", r);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_opcode = 6'd0; bus.in_funct = 6'd0; bus.in_rt = 5'd0;
    bus.in_rs_val = 32'd0; bus.in_rt_val = 32'd0; bus.in_imm = 16'd0; bus.in_pc = 32'd0;
    test_reset();
    test_directed();
    test_illegal_hold();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
